// File: rtl/alu_issue_stage.sv
// Decode/issue register between register read and EX: decodes one MIPS instruction into
// registered ALU control, operands and stage control bits, with stall, flush and bubble support.
module alu_issue_stage #(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    input  logic [31:0] Instr,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        Stall,
    input  logic        Flush,
    output logic        OutValid,
    output logic [5:0]  ALUControl,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  DestReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  MemSize,
    output logic        IsBranch,
    output logic        IllegalInstr
);

    localparam logic [5:0] ALU_ADD = 6'b100000;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt_f, rd_f, shamt;
    logic [31:0] imm_sext, imm_zext;

    assign opcode   = Instr[31:26];
    assign rt_f     = Instr[20:16];
    assign rd_f     = Instr[15:11];
    assign shamt    = Instr[10:6];
    assign funct    = Instr[5:0];
    assign imm_sext = {{16{Instr[15]}}, Instr[15:0]};
    assign imm_zext = {16'b0, Instr[15:0]};

    logic        dec_legal, dec_wr, dec_mr, dec_mw, dec_br;
    logic [5:0]  dec_alu;
    logic [31:0] dec_a, dec_b;
    logic [4:0]  dec_dest;
    logic [1:0]  dec_size;

    always_comb begin
        dec_legal = 1'b1;
        dec_alu   = ALU_ADD;
        dec_a     = 32'b0;
        dec_b     = 32'b0;
        dec_dest  = 5'b0;
        dec_wr    = 1'b0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_size  = 2'b00;
        dec_br    = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100111, 6'b100110, 6'b101010: begin
                        dec_alu = funct; dec_a = RsData; dec_b = RtData;
                        dec_dest = rd_f; dec_wr = 1'b1;
                    end
                    6'b000000, 6'b000010: begin
                        dec_alu = funct; dec_a = RtData; dec_b = {27'b0, shamt};
                        dec_dest = rd_f; dec_wr = 1'b1;
                    end
                    6'b001000: begin
                        dec_alu = 6'b001000; dec_a = RsData;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'b011100: begin
                if (funct == 6'b000010) begin
                    dec_alu = 6'b011000; dec_a = RsData; dec_b = RtData;
                    dec_dest = rd_f; dec_wr = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            6'b001000, 6'b001010: begin
                dec_alu = (opcode == 6'b001000) ? ALU_ADD : 6'b101010;
                dec_a = RsData; dec_b = imm_sext; dec_dest = rt_f; dec_wr = 1'b1;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                dec_alu = {4'b1001, opcode[1:0]};
                dec_a = RsData; dec_b = imm_zext; dec_dest = rt_f; dec_wr = 1'b1;
            end
            // opcode[1:0] distinguishes word (11), half (01) and byte (00) accesses
            6'b100011, 6'b100001, 6'b100000: begin
                dec_a = RsData; dec_b = imm_sext; dec_dest = rt_f; dec_wr = 1'b1;
                dec_mr = 1'b1;
                dec_size = (opcode[1:0] == 2'b11) ? 2'b00 : (opcode[0] ? 2'b01 : 2'b10);
            end
            6'b101011, 6'b101001, 6'b101000: begin
                dec_a = RsData; dec_b = imm_sext; dec_mw = 1'b1;
                dec_size = (opcode[1:0] == 2'b11) ? 2'b00 : (opcode[0] ? 2'b01 : 2'b10);
            end
            6'b000100, 6'b000101: begin
                dec_alu = opcode; dec_a = RsData; dec_b = RtData; dec_br = 1'b1;
            end
            6'b000110, 6'b000111: begin
                dec_alu = opcode; dec_a = RsData; dec_br = 1'b1;
            end
            6'b000001: begin
                if (rt_f == 5'b00001 || rt_f == 5'b00000) begin
                    dec_alu = 6'b000001; dec_a = RsData; dec_b = {31'b0, rt_f[0]};
                    dec_br = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            6'b000010, 6'b000011: ;
            default: dec_legal = 1'b0;
        endcase
        if (dec_dest == 5'b0) dec_wr = 1'b0;
    end

    logic        valid_q, valid_d, wr_q, wr_d, mr_q, mr_d, mw_q, mw_d;
    logic        br_q, br_d, ill_q, ill_d;
    logic [5:0]  alu_q, alu_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  dest_q, dest_d;
    logic [1:0]  size_q, size_d;

    always_comb begin
        valid_d = valid_q; alu_d = alu_q; a_d = a_q; b_d = b_q; dest_d = dest_q;
        wr_d = wr_q; mr_d = mr_q; mw_d = mw_q; size_d = size_q; br_d = br_q; ill_d = ill_q;
        // Flush overrides Stall; anything other than a held stall starts from a bubble
        if (Flush || !Stall) begin
            valid_d = 1'b0; alu_d = ALU_ADD; a_d = 32'b0; b_d = 32'b0; dest_d = 5'b0;
            wr_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; size_d = 2'b00; br_d = 1'b0; ill_d = 1'b0;
            if (!Flush && InValid) begin
                if (dec_legal) begin
                    valid_d = 1'b1; alu_d = dec_alu; a_d = dec_a; b_d = dec_b;
                    dest_d = dec_dest; wr_d = dec_wr; mr_d = dec_mr; mw_d = dec_mw;
                    size_d = dec_size; br_d = dec_br;
                end else begin
                    ill_d = TRAP_ILLEGAL;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0; alu_q <= ALU_ADD; a_q <= 32'b0; b_q <= 32'b0; dest_q <= 5'b0;
            wr_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0; size_q <= 2'b00; br_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            valid_q <= valid_d; alu_q <= alu_d; a_q <= a_d; b_q <= b_d; dest_q <= dest_d;
            wr_q <= wr_d; mr_q <= mr_d; mw_q <= mw_d; size_q <= size_d; br_q <= br_d;
            ill_q <= ill_d;
        end
    end

    assign OutValid     = valid_q;
    assign ALUControl   = alu_q;
    assign A            = a_q;
    assign B            = b_q;
    assign DestReg      = dest_q;
    assign RegWrite     = wr_q;
    assign MemRead      = mr_q;
    assign MemWrite     = mw_q;
    assign MemSize      = size_q;
    assign IsBranch     = br_q;
    assign IllegalInstr = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-computed expected outputs after each clock edge.
module tb_alu_issue_stage;

    logic        Clk = 1'b0;
    logic        Rst, InValid, Stall, Flush;
    logic [31:0] Instr, RsData, RtData;
    logic        OutValid, RegWrite, MemRead, MemWrite, IsBranch, IllegalInstr;
    logic [5:0]  ALUControl;
    logic [31:0] A, B;
    logic [4:0]  DestReg;
    logic [1:0]  MemSize;

    int tests_run = 0;
    int tests_failed = 0;

    alu_issue_stage #(.TRAP_ILLEGAL(1'b1)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .Instr(Instr), .RsData(RsData),
        .RtData(RtData), .Stall(Stall), .Flush(Flush), .OutValid(OutValid),
        .ALUControl(ALUControl), .A(A), .B(B), .DestReg(DestReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .IsBranch(IsBranch),
        .IllegalInstr(IllegalInstr)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt);
        InValid = v; Instr = ins; RsData = rs; RtData = rt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ov, alu, a, b, dest, rw, mr, mw, size, br, ill
    task automatic chk_all(input string tag, input logic ov, input logic [5:0] alu,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [4:0] dst,
                           input logic rw, input logic mr, input logic mw,
                           input logic [1:0] sz, input logic br, input logic ill);
        chk({tag, ".OutValid"},     {31'b0, OutValid},     {31'b0, ov});
        chk({tag, ".ALUControl"},   {26'b0, ALUControl},   {26'b0, alu});
        chk({tag, ".A"},            A,                     ea);
        chk({tag, ".B"},            B,                     eb);
        chk({tag, ".DestReg"},      {27'b0, DestReg},      {27'b0, dst});
        chk({tag, ".RegWrite"},     {31'b0, RegWrite},     {31'b0, rw});
        chk({tag, ".MemRead"},      {31'b0, MemRead},      {31'b0, mr});
        chk({tag, ".MemWrite"},     {31'b0, MemWrite},     {31'b0, mw});
        chk({tag, ".MemSize"},      {30'b0, MemSize},      {30'b0, sz});
        chk({tag, ".IsBranch"},     {31'b0, IsBranch},     {31'b0, br});
        chk({tag, ".IllegalInstr"}, {31'b0, IllegalInstr}, {31'b0, ill});
    endtask

    task automatic chk_bubble(input string tag, input logic ill);
        chk_all(tag, 1'b0, 6'b100000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, ill);
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step(); step();
        chk_bubble("reset", 1'b0);
        Rst = 1'b0;

        drive(1'b1, 32'h00221820, 32'd5, 32'd7);                 // add $3,$1,$2
        step();
        chk_all("add", 1'b1, 6'b100000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b1, 32'h2025FFFC, 32'd10, 32'd0);                // addi $5,$1,-4
        step();
        chk_all("addi", 1'b1, 6'b100000, 32'd10, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b1, 32'h3426FFFC, 32'd10, 32'd0);                // ori $6,$1,0xFFFC
        step();
        chk_all("ori", 1'b1, 6'b100101, 32'd10, 32'h0000FFFC, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b1, 32'h000410C0, 32'hDEAD, 32'h1);              // sll $2,$4,3
        step();
        chk_all("sll", 1'b1, 6'b000000, 32'h1, 32'd3, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b1, 32'h04210010, 32'h80000000, 32'h5);          // bgez $1
        step();
        chk_all("bgez", 1'b1, 6'b000001, 32'h80000000, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

        drive(1'b1, 32'h8C270008, 32'h100, 32'h0);               // lw $7,8($1)
        step();
        chk_all("lw", 1'b1, 6'b100000, 32'h100, 32'd8, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b1, 32'hA027FFFC, 32'h100, 32'h55);              // sb $7,-4($1)
        step();
        chk_all("sb", 1'b1, 6'b100000, 32'h100, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);

        drive(1'b1, 32'h70221802, 32'd6, 32'd9);                 // mul $3,$1,$2
        step();
        chk_all("mul", 1'b1, 6'b011000, 32'd6, 32'd9, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b1, 32'h00000000, 32'h11, 32'h22);               // sll $0,$0,0
        step();
        chk_all("nop", 1'b1, 6'b000000, 32'h22, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b0, 32'h00221820, 32'd5, 32'd7);
        step();
        chk_bubble("invalid", 1'b0);

        drive(1'b1, 32'hFC000000, 32'd1, 32'd2);                 // opcode 0x3F
        step();
        chk_bubble("illegal_op", 1'b1);
        Stall = 1'b1;
        drive(1'b1, 32'h00221820, 32'd5, 32'd7);
        step();
        chk_bubble("illegal_stall", 1'b1);
        Stall = 1'b0;
        step();
        chk_all("after_illegal", 1'b1, 6'b100000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        drive(1'b1, 32'h04220000, 32'd1, 32'd2);                 // REGIMM rt=2
        step();
        chk_bubble("illegal_regimm", 1'b1);
        drive(1'b1, 32'h00000001, 32'd1, 32'd2);                 // R funct 000001
        step();
        chk_bubble("illegal_funct", 1'b1);

        drive(1'b1, 32'h00221820, 32'd5, 32'd7);
        step();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h2025FFFC + i, 32'd100 + i, 32'd200 + i);
            step();
            chk_all("stall", 1'b1, 6'b100000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        Flush = 1'b1;
        step();
        chk_bubble("stall_flush", 1'b0);
        Stall = 1'b0; Flush = 1'b0;

        drive(1'b1, 32'h00221820, 32'd5, 32'd7);
        step();
        Flush = 1'b1;
        step();
        chk_bubble("flush", 1'b0);
        Flush = 1'b0;

        step();
        Rst = 1'b1;
        step();
        chk_bubble("rst_mid1", 1'b0);
        step();
        chk_bubble("rst_mid2", 1'b0);
        Rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
